// File: rtl/mirfak_muldiv_iter.sv
// Iterative RV32M/RV64M multiply/divide engine for the Mirfak EX stage.
// Shift-add multiply and restoring divide share one accumulator; divide corner cases may bypass iteration.
module mirfak_muldiv_iter #(
    parameter int unsigned XLEN            = 32,
    parameter int unsigned BITS_PER_CYCLE  = 1,
    parameter bit          ENABLE_FAST_DIV = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic [2:0]      op_cmd_i,
    input  logic            op_enable_i,
    input  logic            op_consume_i,
    input  logic            op_abort_i,
    output logic [XLEN-1:0] result_o,
    output logic            ack_o,
    output logic            busy_o
);

    localparam int unsigned N  = XLEN / BITS_PER_CYCLE;
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_cmd;
    logic              r_neg_q, r_neg_r;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_x, r_y, r_result;
    logic              r_ack;

    logic              w_is_div, w_sgn_a, w_sgn_b, w_neg_a, w_neg_b;
    logic [XLEN-1:0]   w_mag_a, w_mag_b, w_fast_res, w_fin;
    logic              w_b_zero, w_ovf, w_fast, w_accept, w_ld_fast, w_ld_iter;
    logic [2*XLEN-1:0] w_acc_it, w_prod;
    logic [XLEN-1:0]   w_x_it, w_quo, w_rem;
    logic [XLEN:0]     w_trial, w_sum;

    // Operand decode at accept: signedness per funct3, magnitudes, fast-path detection
    assign w_is_div   = op_cmd_i[2];
    assign w_sgn_a    = w_is_div ? ~op_cmd_i[0] : (op_cmd_i[1:0] == 2'b01 || op_cmd_i[1:0] == 2'b10);
    assign w_sgn_b    = w_is_div ? ~op_cmd_i[0] : (op_cmd_i[1:0] == 2'b01);
    assign w_neg_a    = w_sgn_a & op_a_i[XLEN-1];
    assign w_neg_b    = w_sgn_b & op_b_i[XLEN-1];
    assign w_mag_a    = w_neg_a ? -op_a_i : op_a_i;
    assign w_mag_b    = w_neg_b ? -op_b_i : op_b_i;
    assign w_b_zero   = (op_b_i == '0);
    assign w_ovf      = ~op_cmd_i[0] & (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) & (op_b_i == '1);
    assign w_fast     = ENABLE_FAST_DIV && w_is_div && (w_b_zero || w_ovf);
    assign w_fast_res = w_b_zero ? (op_cmd_i[1] ? op_a_i : '1) : (op_cmd_i[1] ? '0 : op_a_i);
    assign w_accept   = (r_state == S_IDLE) && op_enable_i && !op_abort_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = w_fast ? S_DONE : S_BUSY;
            S_BUSY:  if (r_cnt == CW'(1)) w_state_nxt = S_DONE;
            S_DONE:  if (op_consume_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (op_abort_i) w_state_nxt = S_IDLE;
    end

    always_comb begin
        busy_o    = op_enable_i && !r_ack;
        w_ld_fast = w_accept && w_fast;
        w_ld_iter = (r_state == S_BUSY) && (r_cnt == CW'(1)) && !op_abort_i;
    end

    // One iteration: BITS_PER_CYCLE multiplier bits (LSB first) or quotient bits (MSB first)
    always_comb begin
        w_acc_it = r_acc;
        w_x_it   = r_x;
        w_trial  = '0;
        w_sum    = '0;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            if (r_cmd[2]) begin
                w_trial = {w_acc_it[XLEN-1:0], w_x_it[XLEN-1]};
                w_x_it  = {w_x_it[XLEN-2:0], 1'b0};
                if (w_trial >= {1'b0, r_y}) begin
                    w_trial   = w_trial - {1'b0, r_y};
                    w_x_it[0] = 1'b1;
                end
                w_acc_it[XLEN-1:0] = w_trial[XLEN-1:0];
            end else begin
                w_sum    = {1'b0, w_acc_it[2*XLEN-1:XLEN]} + (w_x_it[0] ? {1'b0, r_y} : '0);
                w_acc_it = {w_sum, w_acc_it[XLEN-1:1]};
                w_x_it   = {1'b0, w_x_it[XLEN-1:1]};
            end
        end
        w_prod = r_neg_q ? -w_acc_it : w_acc_it;
        w_quo  = r_neg_q ? -w_x_it : w_x_it;
        w_rem  = r_neg_r ? -w_acc_it[XLEN-1:0] : w_acc_it[XLEN-1:0];
        case (r_cmd)
            3'b000:         w_fin = w_prod[XLEN-1:0];
            3'b100, 3'b101: w_fin = w_quo;
            3'b110, 3'b111: w_fin = w_rem;
            default:        w_fin = w_prod[2*XLEN-1:XLEN];
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt    <= '0;
            r_cmd    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_acc    <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_result <= '0;
            r_ack    <= 1'b0;
        end else begin
            r_ack <= (w_state_nxt == S_DONE);
            if (w_accept) begin
                r_cmd   <= op_cmd_i;
                r_cnt   <= CW'(N);
                r_acc   <= '0;
                r_x     <= w_mag_a;
                r_y     <= w_mag_b;
                // A zero divisor keeps the all-ones quotient unsigned-looking for signed DIV
                r_neg_q <= (w_neg_a ^ w_neg_b) & ~w_b_zero;
                r_neg_r <= w_neg_a;
            end else if (r_state == S_BUSY) begin
                r_acc <= w_acc_it;
                r_x   <= w_x_it;
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_ld_fast)      r_result <= w_fast_res;
            else if (w_ld_iter) r_result <= w_fin;
        end
    end

    assign result_o = r_result;
    assign ack_o    = r_ack;

endmodule

// File: tb/tb_mirfak_muldiv_iter.sv
// Scoreboard bench for mirfak_muldiv_iter: three instances (BPC1/fast, BPC4/fast, BPC1/no-fast).
module tb_mirfak_muldiv_iter;

    localparam logic [2:0] C_MUL = 3'd0, C_MULH = 3'd1, C_MULHSU = 3'd2, C_MULHU = 3'd3;
    localparam logic [2:0] C_DIV = 3'd4, C_DIVU = 3'd5, C_REM = 3'd6, C_REMU = 3'd7;

    typedef struct {
        int unsigned dut;
        logic [31:0] res;
        int unsigned at;
    } exp_t;

    logic        clk, rst, consume, abort;
    logic [31:0] a, b;
    logic [2:0]  cmd;
    logic [2:0]  en, ack, busy;
    logic [31:0] res [3];
    int unsigned cyc;
    int          total, bad;
    exp_t        sb [$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mirfak_muldiv_iter #(
            .XLEN(32),
            .BITS_PER_CYCLE((g == 1) ? 4 : 1),
            .ENABLE_FAST_DIV((g == 2) ? 1'b0 : 1'b1)
        ) u_dut (
            .clk_i(clk), .rst_i(rst), .op_a_i(a), .op_b_i(b), .op_cmd_i(cmd),
            .op_enable_i(en[g]), .op_consume_i(consume), .op_abort_i(abort),
            .result_o(res[g]), .ack_o(ack[g]), .busy_o(busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int unsigned sel, input logic [31:0] r, input int unsigned at);
        exp_t e;
        e.dut = sel; e.res = r; e.at = at;
        sb.push_back(e);
    endtask

    // Pops one expectation on each rising ack of any instance
    task automatic monitor_loop();
        logic [2:0] prev = 3'b000;
        exp_t e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (ack[d] && !prev[d]) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_ack", 32'(d), 32'hFFFFFFFF);
                    end else begin
                        e = sb.pop_front();
                        chk("ack_dut", 32'(d), 32'(e.dut));
                        chk("ack_result", res[d], e.res);
                        chk("ack_cycle", cyc, e.at);
                    end
                end
                prev[d] = ack[d];
            end
        end
    endtask

    task automatic start_op(input int unsigned sel, input logic [2:0] c, input logic [31:0] va,
                            input logic [31:0] vb, input logic [31:0] r, input int unsigned lat);
        @(negedge clk);
        a = va; b = vb; cmd = c; en[sel] = 1'b1;
        push_exp(sel, r, cyc + lat);
    endtask

    task automatic wait_ack(input int unsigned sel);
        bit got = 1'b0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            got = ack[sel];
        end
        if (!got) chk("ack_timeout", 32'(sel), 32'hFFFFFFFF);
    endtask

    task automatic finish_op(input int unsigned sel);
        wait_ack(sel);
        chk("busy_in_ack", 32'(busy[sel]), 32'd0);
        consume = 1'b1;
        @(negedge clk);
        consume = 1'b0; en[sel] = 1'b0;
        chk("ack_after_consume", 32'(ack[sel]), 32'd0);
    endtask

    task automatic do_op(input int unsigned sel, input logic [2:0] c, input logic [31:0] va,
                         input logic [31:0] vb, input logic [31:0] r, input int unsigned lat);
        start_op(sel, c, va, vb, r, lat);
        finish_op(sel);
    endtask

    initial begin
        rst = 1'b1; en = '0; consume = 1'b0; abort = 1'b0; a = '0; b = '0; cmd = '0;
        total = 0; bad = 0;
        fork monitor_loop(); join_none
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("reset_ack", 32'(ack[d]), 32'd0);
            chk("reset_result", res[d], 32'd0);
            chk("reset_busy", 32'(busy[d]), 32'd0);
        end

        // Default instance: full iterations and fast path
        do_op(0, C_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        do_op(0, C_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        do_op(0, C_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
        do_op(0, C_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
        do_op(0, C_MULH,   32'h80000000, 32'd2,        32'hFFFFFFFF, 33);
        do_op(0, C_DIVU,   32'd100,      32'd7,        32'd14,       33);
        do_op(0, C_REMU,   32'd100,      32'd7,        32'd2,        33);
        do_op(0, C_DIV,    32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 33);
        do_op(0, C_REM,    32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 33);
        do_op(0, C_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33);
        do_op(0, C_REMU,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
        do_op(0, C_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1);
        do_op(0, C_REM,    32'd5,        32'd0,        32'd5,        1);
        do_op(0, C_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1);
        do_op(0, C_REMU,   32'd5,        32'd0,        32'd5,        1);
        do_op(0, C_DIV,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1);
        do_op(0, C_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        do_op(0, C_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

        // Abort in cycle 10 of a DIVU, then MUL 3x4 accepted in cycle 11
        @(negedge clk);
        a = 32'd100; b = 32'd7; cmd = C_DIVU; en[0] = 1'b1;
        repeat (10) @(negedge clk);
        abort = 1'b1;
        chk("abort_pre_ack", 32'(ack[0]), 32'd0);
        @(negedge clk);
        abort = 1'b0; a = 32'd3; b = 32'd4; cmd = C_MUL;
        push_exp(0, 32'd12, cyc + 33);
        chk("abort_idle_ack", 32'(ack[0]), 32'd0);
        chk("abort_idle_busy", 32'(busy[0]), 32'd1);
        finish_op(0);

        // Abort in the ack cycle without consume still drops the result
        start_op(0, C_MUL, 32'd2, 32'd3, 32'd6, 33);
        wait_ack(0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; en[0] = 1'b0;
        chk("abort_done_ack", 32'(ack[0]), 32'd0);

        // Asynchronous reset mid-BUSY clears the held result without a clock edge
        @(negedge clk);
        a = 32'd1000; b = 32'd3; cmd = C_DIVU; en[0] = 1'b1;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_busy_ack", 32'(ack[0]), 32'd0);
        chk("rst_busy_result", res[0], 32'd0);
        @(negedge clk);
        en[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        do_op(0, C_MUL, 32'd3, 32'd4, 32'd12, 33);

        // Stall five cycles in DONE, then back-to-back op with enable held high
        start_op(0, C_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        wait_ack(0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_ack", 32'(ack[0]), 32'd1);
            chk("stall_result", res[0], 32'hFFFFFFFE);
            chk("stall_busy", 32'(busy[0]), 32'd0);
            a = 32'd0; cmd = C_DIV;
        end
        consume = 1'b1; a = 32'd7; b = 32'hFFFFFFFD; cmd = C_MUL;
        push_exp(0, 32'hFFFFFFEB, cyc + 1 + 33);
        @(negedge clk);
        consume = 1'b0;
        chk("b2b_idle_ack", 32'(ack[0]), 32'd0);
        chk("b2b_idle_busy", 32'(busy[0]), 32'd1);
        wait_ack(0);
        #2 rst = 1'b1;
        #1;
        chk("rst_done_ack", 32'(ack[0]), 32'd0);
        chk("rst_done_result", res[0], 32'd0);
        @(negedge clk);
        en[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Four bits per cycle
        do_op(1, C_MUL,   32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 9);
        do_op(1, C_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 9);
        do_op(1, C_DIVU,  32'd100,      32'd7,        32'd14,       9);
        do_op(1, C_REMU,  32'd100,      32'd7,        32'd2,        9);
        do_op(1, C_DIV,   32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 9);
        do_op(1, C_REM,   32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 9);

        // Fast path disabled: same values through full iteration
        do_op(2, C_DIV, 32'd5,        32'd0,        32'hFFFFFFFF, 33);
        do_op(2, C_REM, 32'd5,        32'd0,        32'd5,        33);
        do_op(2, C_DIV, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 33);
        do_op(2, C_REM, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 33);
        do_op(2, C_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
        do_op(2, C_REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
